// File: rtl/seq_sub_if.sv
// Handshake and data bundle for the sequential subtractor.
// The requester drives start and the operands; the subtractor returns
// status, the result and its flags.
interface seq_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero
  );
endinterface

// File: rtl/seq_sub.sv
// Sequential subtractor: computes a - b - bin over N = WIDTH/STEP cycles,
// STEP bits per cycle, LSB slice first, with the borrow rippling from one
// slice to the next. Result, borrow-out and zero flag update together on
// completion and hold until the next operation finishes.
module seq_sub #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_sub_if.slave bus
);

  localparam int N  = (STEP > 0) ? (WIDTH / STEP) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Reject parameter sets that cannot be split into whole slices
  generate
    if (WIDTH < 1 || STEP < 1 || STEP > WIDTH ||
        ((STEP > 0) ? (WIDTH % STEP) : 1) != 0) begin : g_bad_params
      $error("seq_sub: STEP must be in 1..WIDTH and divide WIDTH exactly");
    end
  endgenerate

  // One slice of the subtraction; the MSB of the result is the borrow out
  function automatic logic [STEP:0] sub_slice(
    input logic [STEP-1:0] x,
    input logic [STEP-1:0] y,
    input logic            bi
  );
    return {1'b0, x} - {1'b0, y} - {{STEP{1'b0}}, bi};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             brw_q,   brw_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             bout_q,  bout_d;
  logic             zero_q,  zero_d;
  logic             done_q,  done_d;

  logic [STEP:0]    slice_res;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] acc_next;

  // Next-state logic: capture on accept, then one slice per cycle. The
  // operand registers shift right so the active slice always sits at the
  // LSBs, and finished slices enter the accumulator from the top so that
  // after N shifts slice 0 has landed in the LSBs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    slice_res = sub_slice(a_q[STEP-1:0], b_q[STEP-1:0], brw_q);
    slice_ext = '0;
    slice_ext[STEP-1:0] = slice_res[STEP-1:0];
    acc_next  = (acc_q >> STEP) | (slice_ext << (WIDTH - STEP));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: begin
        a_d   = a_q >> STEP;
        b_d   = b_q >> STEP;
        brw_d = slice_res[STEP];
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          diff_d  = acc_next;
          bout_d  = slice_res[STEP];
          zero_d  = (acc_next == '0);
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset clears control, operands and outputs alike
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_sub.sv
// Directed bench for seq_sub: a 16-bit/4-bit-step instance for the main
// scenarios and three 4-bit instances (STEP 1, 2, 4) swept exhaustively.
module tb_seq_sub;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  seq_sub_if #(.WIDTH(16)) if16 ();
  seq_sub_if #(.WIDTH(4))  if_s1 ();
  seq_sub_if #(.WIDTH(4))  if_s2 ();
  seq_sub_if #(.WIDTH(4))  if_s4 ();

  seq_sub #(.WIDTH(16), .STEP(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  seq_sub #(.WIDTH(4),  .STEP(1)) u_dut_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1));
  seq_sub #(.WIDTH(4),  .STEP(2)) u_dut_s2 (.clk(clk), .rst_n(rst_n), .bus(if_s2));
  seq_sub #(.WIDTH(4),  .STEP(4)) u_dut_s4 (.clk(clk), .rst_n(rst_n), .bus(if_s4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 16-bit instance with hand-computed expectations
  task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ibin, input logic [15:0] ed, input logic eb,
                       input logic ez);
    logic [17:0] prev;
    int lat;
    int bcnt;
    prev = {if16.bout, if16.zero, if16.diff};
    if16.a = ia; if16.b = ib; if16.bin = ibin; if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    if16.a = ~ia; if16.b = ~ib; if16.bin = ~ibin;
    lat = 0; bcnt = 0;
    while (!if16.done && lat < 20) begin
      if (if16.busy) bcnt++;
      chk({tag, "_hold"}, {if16.bout, if16.zero, if16.diff}, prev);
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_busycyc"}, bcnt, 4);
    chk({tag, "_busy_at_done"}, if16.busy, 1'b0);
    chk({tag, "_diff"}, if16.diff, ed);
    chk({tag, "_bout"}, if16.bout, eb);
    chk({tag, "_zero"}, if16.zero, ez);
    tick();
    chk({tag, "_done_1cyc"}, if16.done, 1'b0);
  endtask

  initial begin : main
    logic [15:0] av [0:19];
    logic [15:0] bv [0:19];
    logic        bi [0:19];
    logic [16:0] e17;
    logic [4:0]  e5;
    logic [5:0]  got_res [0:2];
    int          got_lat [0:2];
    logic [3:0]  ta;
    logic [3:0]  tb4;
    logic        tbi;
    int          k;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
    if_s1.start = 1'b0; if_s1.a = '0; if_s1.b = '0; if_s1.bin = 1'b0;
    if_s2.start = 1'b0; if_s2.a = '0; if_s2.b = '0; if_s2.bin = 1'b0;
    if_s4.start = 1'b0; if_s4.a = '0; if_s4.b = '0; if_s4.bin = 1'b0;
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", if16.busy, 1'b0);
    chk("rst_done", if16.done, 1'b0);
    chk("rst_diff", if16.diff, 16'h0000);
    chk("rst_bout", if16.bout, 1'b0);
    chk("rst_zero", if16.zero, 1'b0);
    rst_n = 1'b1;
    tick();

    do_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("zero",    16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    do_op("wrapzero",16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1);

    // start held high with operands changing every cycle
    for (int i = 0; i < 20; i++) begin
      av[i] = 16'(i * 16'h1357 + 16'h00F0);
      bv[i] = 16'(i * 16'h2468 + 16'h0011);
      bi[i] = i[0];
    end
    if16.start = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if16.a = av[t-1]; if16.b = bv[t-1]; if16.bin = bi[t-1];
      tick();
      chk("stream_done", if16.done, (t % 5 == 0));
      if (t % 5 == 0) begin
        k = t - 5;
        e17 = {1'b0, av[k]} - {1'b0, bv[k]} - {16'h0000, bi[k]};
        chk("stream_res", {if16.bout, if16.zero, if16.diff},
            {e17[16], (e17[15:0] == 16'h0000), e17[15:0]});
      end
    end
    if16.start = 1'b0;
    tick();
    chk("stream_no_extra", if16.done, 1'b0);
    tick();

    // reset in the middle of an operation
    do_op("pre_abort", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    if16.a = 16'h5555; if16.b = 16'h1111; if16.bin = 1'b0; if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", if16.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", if16.busy, 1'b0);
    chk("abort_done", if16.done, 1'b0);
    chk("abort_diff", if16.diff, 16'h0000);
    chk("abort_bout", if16.bout, 1'b0);
    chk("abort_zero", if16.zero, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("abort_no_done", if16.done, 1'b0);
    end
    do_op("after_abort", 16'h5555, 16'h1111, 1'b1, 16'h4443, 1'b0, 1'b0);

    // exhaustive sweep of the 4-bit instances with STEP 1, 2 and 4
    for (int i = 0; i < 512; i++) begin
      ta = i[3:0]; tb4 = i[7:4]; tbi = i[8];
      for (int d = 0; d < 3; d++) begin
        got_res[d] = 'x;
        got_lat[d] = -1;
      end
      if_s1.a = ta; if_s1.b = tb4; if_s1.bin = tbi; if_s1.start = 1'b1;
      if_s2.a = ta; if_s2.b = tb4; if_s2.bin = tbi; if_s2.start = 1'b1;
      if_s4.a = ta; if_s4.b = tb4; if_s4.bin = tbi; if_s4.start = 1'b1;
      tick();
      if_s1.start = 1'b0; if_s2.start = 1'b0; if_s4.start = 1'b0;
      for (int t = 1; t <= 6; t++) begin
        tick();
        if (got_lat[0] < 0 && if_s1.done) begin
          got_lat[0] = t; got_res[0] = {if_s1.bout, if_s1.zero, if_s1.diff};
        end
        if (got_lat[1] < 0 && if_s2.done) begin
          got_lat[1] = t; got_res[1] = {if_s2.bout, if_s2.zero, if_s2.diff};
        end
        if (got_lat[2] < 0 && if_s4.done) begin
          got_lat[2] = t; got_res[2] = {if_s4.bout, if_s4.zero, if_s4.diff};
        end
      end
      e5 = {1'b0, ta} - {1'b0, tb4} - {4'h0, tbi};
      chk("ex_s1_res", got_res[0], {e5[4], (e5[3:0] == 4'h0), e5[3:0]});
      chk("ex_s2_res", got_res[1], {e5[4], (e5[3:0] == 4'h0), e5[3:0]});
      chk("ex_s4_res", got_res[2], {e5[4], (e5[3:0] == 4'h0), e5[3:0]});
      chk("ex_s1_lat", got_lat[0], 4);
      chk("ex_s2_lat", got_lat[1], 2);
      chk("ex_s4_lat", got_lat[2], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
